// File: rtl/spi_send_pkg.sv
// spi_send_pkg: shared types and constants for the SPI send queue.
package spi_send_pkg;

    // Cycles to wait for the transmitter's busy before treating a word as sent.
    localparam int unsigned ACK_TIMEOUT = 4;
    localparam int unsigned BYTE_LANES  = 4;
    localparam int unsigned DATA_W      = 8 * BYTE_LANES;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    // One queued word: byte-valid mask above the data.
    typedef struct packed {
        logic [BYTE_LANES-1:0] valid;
        logic [DATA_W-1:0]     data;
    } entry_t;

endpackage

// File: rtl/send_fifo_mem.sv
// send_fifo_mem: DEPTH-entry storage for the send queue with one write port
// and a registered read port. The read register doubles as the transmit
// holding register, so it keeps its value until the next read.
module send_fifo_mem
    import spi_send_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];
    entry_t rdata_q;

    // Storage write; the array itself carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read: captures the addressed entry on a read, else holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_send_queue.sv
// spi_send_queue: FIFO feeder for the SPI transmitter. Buffers words with
// byte-valid masks and issues them one at a time over send/busy.
// DEPTH must be a power of 2 and at least 2.
// Optional statistics outputs (drop_count, words_sent) are built when the
// macro SPI_SEND_QUEUE_STATS_EN is defined.
module spi_send_queue
    import spi_send_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_valid,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   send,
    output logic [31:0]            send_data,
    output logic [3:0]             send_valid,
    input  logic                   busy
`ifdef SPI_SEND_QUEUE_STATS_EN
    ,
    output logic [15:0]            drop_count,
    output logic [15:0]            words_sent
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          ovf_q, ovf_d;
    logic          send_q;

    logic          push_req, push, pop, reject;
    entry_t        wr_entry, rd_entry;

    // Push/pop qualification. A pop frees a slot, so a push while full is
    // still accepted when it coincides with one; flush cancels both.
    always_comb begin
        push_req = wr_en && (wr_valid != '0);
        pop      = (state_q == ISSUE) && !empty_q && !flush;
        push     = push_req && !flush && (!full_q || pop);
        reject   = push_req && !flush && full_q && !pop;
    end

    // Pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (reject) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Issue FSM next-state; timer counts idle WAIT_ACK cycles.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (!empty_q && !busy && !flush) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = pop ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; full/empty are registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            send_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
            send_q   <= pop;
        end
    end

    assign wr_entry = '{valid: wr_valid, data: wr_data};

    send_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign send       = send_q;
    assign send_data  = rd_entry.data;
    assign send_valid = rd_entry.valid;

`ifdef SPI_SEND_QUEUE_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic [15:0] sent_q, sent_d;

    // Statistics next-state: drops saturate and clear on flush, sends wrap.
    always_comb begin
        drop_d = drop_q;
        sent_d = sent_q;
        if (flush) begin
            drop_d = '0;
        end else if (reject && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
        if (pop) begin
            sent_d = sent_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            sent_q <= '0;
        end else begin
            drop_q <= drop_d;
            sent_q <= sent_d;
        end
    end

    assign drop_count = drop_q;
    assign words_sent = sent_q;
`endif

endmodule
